// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller for a 5-stage MIPS core: turns ID-stage hazard flags
// into per-stage write enables, sequences JR/JALR stalls and the HALT drain.
module pipeline_stall_ctrl #(
  parameter int JR_STALL_CYCLES = 3,
  parameter int DRAIN_CYCLES    = 3,
  parameter int CNT_W           = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall_load,
  input  logic        i_stall_jump_reg,
  input  logic        i_halt,
  input  logic        i_run,
  output logic        o_pc_wr_en,
  output logic        o_if_id_wr_en,
  output logic        o_id_ex_bubble,
  output logic        o_pipe_en,
  output logic        o_halted,
  output logic [31:0] o_cycle_cnt,
  output logic [15:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL_JR = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] JR_LOAD    = CNT_W'(JR_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      cycle_cnt_q, cycle_cnt_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             halted_q, halted_d;
  logic             pc_wr_en, if_id_wr_en, bubble, pipe_en;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_wr_en    = 1'b0;
    if_id_wr_en = 1'b0;
    bubble      = 1'b0;
    pipe_en     = 1'b0;

    // HALTED ignores everything; i_run=0 freezes every other state in place.
    if (state_q != ST_HALTED && i_run) begin
      unique case (state_q)
        ST_RUN: begin
          if (i_halt || i_stall_jump_reg || i_stall_load) begin
            bubble  = 1'b1;
            pipe_en = 1'b1;
          end else begin
            pc_wr_en    = 1'b1;
            if_id_wr_en = 1'b1;
            pipe_en     = 1'b1;
          end
          if (i_halt) begin
            if (DRAIN_CYCLES > 1) begin
              state_d = ST_DRAIN;
              cnt_d   = DRAIN_LOAD;
            end else begin
              state_d = ST_HALTED;
            end
          end else if (i_stall_jump_reg && JR_STALL_CYCLES > 1) begin
            state_d = ST_STALL_JR;
            cnt_d   = JR_LOAD;
          end
        end
        ST_STALL_JR, ST_DRAIN: begin
          bubble  = 1'b1;
          pipe_en = 1'b1;
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE) begin
            state_d = (state_q == ST_DRAIN) ? ST_HALTED : ST_RUN;
          end
        end
        default: ;
      endcase
    end

    cycle_cnt_d = pipe_en ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
    stall_cnt_d = (bubble && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    halted_d    = (state_d == ST_HALTED);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from the values sampled at the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign o_pc_wr_en     = pc_wr_en;
  assign o_if_id_wr_en  = if_id_wr_en;
  assign o_id_ex_bubble = bubble;
  assign o_pipe_en      = pipe_en;
  assign o_halted       = halted_q;
  assign o_cycle_cnt    = cycle_cnt_q;
  assign o_stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: a cycle model pushes expected
// outputs to a scoreboard queue; a negedge monitor pops and compares them.
module tb_pipeline_stall_ctrl;

  localparam int JR_CYC    = 3;
  localparam int DRAIN_CYC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0, ld = 1'b0, jr = 1'b0, hlt = 1'b0, run = 1'b0;
  logic        pc_wr_en, if_id_wr_en, bubble, pipe_en, halted;
  logic [31:0] cycle_cnt;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_stall_ctrl #(
    .JR_STALL_CYCLES(JR_CYC),
    .DRAIN_CYCLES   (DRAIN_CYC),
    .CNT_W          (2)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_stall_load    (ld),
    .i_stall_jump_reg(jr),
    .i_halt          (hlt),
    .i_run           (run),
    .o_pc_wr_en      (pc_wr_en),
    .o_if_id_wr_en   (if_id_wr_en),
    .o_id_ex_bubble  (bubble),
    .o_pipe_en       (pipe_en),
    .o_halted        (halted),
    .o_cycle_cnt     (cycle_cnt),
    .o_stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pc;
    logic        ifid;
    logic        bub;
    logic        pipe;
    logic        hlt;
    logic [31:0] cyc;
    logic [15:0] stl;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: mode 0=run 1=jr stall 2=drain 3=halted; left = stall cycles still owed.
  int          m_mode  = 0;
  int          m_left  = 0;
  logic [31:0] m_cyc   = '0;
  int          m_stl   = 0;
  bit          m_valid = 1'b0;

  function automatic exp_t model_out(input logic l, input logic j, input logic h, input logic r);
    exp_t e;
    e.pc = 0; e.ifid = 0; e.bub = 0; e.pipe = 0;
    e.hlt = (m_mode == 3);
    e.cyc = m_cyc;
    e.stl = 16'(m_stl);
    if (m_mode != 3 && r) begin
      if (m_mode != 0 || h || j || l) begin
        e.bub = 1; e.pipe = 1;
      end else begin
        e.pc = 1; e.ifid = 1; e.pipe = 1;
      end
    end
    return e;
  endfunction

  // One clock cycle: drive inputs after the edge, push expectation, advance the model.
  task automatic step(input logic r, input logic l, input logic j, input logic h, input logic rn);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r; ld = l; jr = j; hlt = h; run = rn;
    #1;
    e = model_out(l, j, h, rn);
    if (m_valid) sb_q.push_back(e);
    if (r) begin
      m_mode = 0; m_left = 0; m_cyc = '0; m_stl = 0; m_valid = 1'b1;
    end else if (m_valid && m_mode != 3 && rn) begin
      if (e.pipe) m_cyc = m_cyc + 32'd1;
      if (e.bub && m_stl < 65535) m_stl++;
      case (m_mode)
        0: if (h) begin
             m_left = DRAIN_CYC - 1;
             m_mode = (m_left > 0) ? 2 : 3;
           end else if (j) begin
             m_left = JR_CYC - 1;
             m_mode = (m_left > 0) ? 1 : 0;
           end
        1: begin m_left--; if (m_left == 0) m_mode = 0; end
        2: begin m_left--; if (m_left == 0) m_mode = 3; end
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks += 8;
      if (pc_wr_en !== e.pc) begin errors++; $display("FAIL sb_pc_wr_en got %b exp %b at %0t", pc_wr_en, e.pc, $time); end
      if (if_id_wr_en !== e.ifid) begin errors++; $display("FAIL sb_if_id_wr_en got %b exp %b at %0t", if_id_wr_en, e.ifid, $time); end
      if (bubble !== e.bub) begin errors++; $display("FAIL sb_bubble got %b exp %b at %0t", bubble, e.bub, $time); end
      if (pipe_en !== e.pipe) begin errors++; $display("FAIL sb_pipe_en got %b exp %b at %0t", pipe_en, e.pipe, $time); end
      if (halted !== e.hlt) begin errors++; $display("FAIL sb_halted got %b exp %b at %0t", halted, e.hlt, $time); end
      if (cycle_cnt !== e.cyc) begin errors++; $display("FAIL sb_cycle_cnt got %0d exp %0d at %0t", cycle_cnt, e.cyc, $time); end
      if (stall_cnt !== e.stl) begin errors++; $display("FAIL sb_stall_cnt got %0d exp %0d at %0t", stall_cnt, e.stl, $time); end
      if (bubble === 1'b1 && (pc_wr_en !== 1'b0 || if_id_wr_en !== 1'b0)) begin
        errors++; $display("FAIL invariant_bubble pc=%b ifid=%b exp 0 0 at %0t", pc_wr_en, if_id_wr_en, $time);
      end
    end
  end

  task automatic test_reset();
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    checks++;
    if ({pc_wr_en, if_id_wr_en, bubble, pipe_en, halted} !== 5'b11010 || cycle_cnt !== 0 || stall_cnt !== 0) begin
      errors++;
      $display("FAIL reset_state got pc%b ifid%b bub%b pipe%b hlt%b cyc%0d stl%0d exp 1 1 0 1 0 0 0",
               pc_wr_en, if_id_wr_en, bubble, pipe_en, halted, cycle_cnt, stall_cnt);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 1);
    checks++;
    if (cycle_cnt !== 32'd10 || stall_cnt !== 16'd0 || pc_wr_en !== 1'b1 || bubble !== 1'b0) begin
      errors++;
      $display("FAIL idle_counts got cyc %0d stl %0d pc %b bub %b exp 10 0 1 0", cycle_cnt, stall_cnt, pc_wr_en, bubble);
    end
  endtask

  task automatic test_load_stall();
    step(0, 1, 0, 0, 1);
    checks++;
    if (pc_wr_en !== 1'b0 || bubble !== 1'b1) begin
      errors++; $display("FAIL load_stall got pc %b bub %b exp 0 1", pc_wr_en, bubble);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (pc_wr_en !== 1'b1 || bubble !== 1'b0 || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL load_release got pc %b bub %b stl %0d exp 1 0 1", pc_wr_en, bubble, stall_cnt);
    end
  endtask

  // hold_load keeps i_stall_load high for the whole JR sequence.
  task automatic test_jr_stall(input logic hold_load, input logic [15:0] exp_stl);
    step(0, hold_load, 1, 0, 1);
    for (int i = 0; i < JR_CYC - 1; i++) begin
      step(0, hold_load, 0, 0, 1);
      checks++;
      if (bubble !== 1'b1) begin errors++; $display("FAIL jr_bubble_%0d got %b exp 1", i, bubble); end
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (bubble !== 1'b0 || pc_wr_en !== 1'b1 || stall_cnt !== exp_stl) begin
      errors++; $display("FAIL jr_end got bub %b pc %b stl %0d exp 0 1 %0d", bubble, pc_wr_en, stall_cnt, exp_stl);
    end
  endtask

  task automatic test_freeze_in_jr();
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if ({pc_wr_en, if_id_wr_en, bubble, pipe_en} !== 4'b0000) begin
        errors++; $display("FAIL freeze_enables got %b exp 0000", {pc_wr_en, if_id_wr_en, bubble, pipe_en});
      end
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (bubble !== 1'b1) begin errors++; $display("FAIL freeze_resume_stall got %b exp 1", bubble); end
    step(0, 0, 0, 0, 1);
    checks++;
    if (bubble !== 1'b0 || stall_cnt !== 16'd10) begin
      errors++; $display("FAIL freeze_resume_end got bub %b stl %0d exp 0 10", bubble, stall_cnt);
    end
  endtask

  task automatic test_halt();
    logic [31:0] cyc_at_halt;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    checks++;
    if (halted !== 1'b1 || pipe_en !== 1'b0 || pc_wr_en !== 1'b0 || bubble !== 1'b0) begin
      errors++; $display("FAIL halt_enter got hlt %b pipe %b pc %b bub %b exp 1 0 0 0", halted, pipe_en, pc_wr_en, bubble);
    end
    cyc_at_halt = m_cyc;
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    checks++;
    if (halted !== 1'b1 || cycle_cnt !== cyc_at_halt) begin
      errors++; $display("FAIL halt_sticky got hlt %b cyc %0d exp 1 %0d", halted, cycle_cnt, cyc_at_halt);
    end
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    checks++;
    if (halted !== 1'b0 || pc_wr_en !== 1'b1) begin
      errors++; $display("FAIL halt_reset got hlt %b pc %b exp 0 1", halted, pc_wr_en);
    end
  endtask

  task automatic test_reset_in_drain();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    checks++;
    if (halted !== 1'b0 || bubble !== 1'b0 || pc_wr_en !== 1'b1 || cycle_cnt !== 0 || stall_cnt !== 0) begin
      errors++;
      $display("FAIL reset_in_drain got hlt %b bub %b pc %b cyc %0d stl %0d exp 0 0 1 0 0",
               halted, bubble, pc_wr_en, cycle_cnt, stall_cnt);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_stall();
    test_jr_stall(1'b0, 16'd4);
    test_jr_stall(1'b1, 16'd7);
    test_freeze_in_jr();
    test_halt();
    test_reset_in_drain();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d entries exp 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
